// File: rtl/udp_reg_ring_master_if.sv
// CPU-side access bus plus ring head/tail signals of the UDP register ring initiator.
interface udp_reg_ring_master_if #(
  parameter int UDP_REG_ADDR_WIDTH  = 23,
  parameter int CPCI_NF2_DATA_WIDTH = 32,
  parameter int UDP_REG_SRC_WIDTH   = 2
);
  logic                           cpu_req;
  logic                           cpu_rd_wr_L;
  logic [UDP_REG_ADDR_WIDTH-1:0]  cpu_addr;
  logic [CPCI_NF2_DATA_WIDTH-1:0] cpu_wr_data;
  logic                           cpu_busy;
  logic                           cpu_ack;
  logic [CPCI_NF2_DATA_WIDTH-1:0] cpu_rd_data;
  logic                           cpu_err;
  logic                           cpu_timeout;

  logic                           reg_req_out;
  logic                           reg_ack_out;
  logic                           reg_rd_wr_L_out;
  logic [UDP_REG_ADDR_WIDTH-1:0]  reg_addr_out;
  logic [CPCI_NF2_DATA_WIDTH-1:0] reg_data_out;
  logic [UDP_REG_SRC_WIDTH-1:0]   reg_src_out;

  logic                           reg_req_in;
  logic                           reg_ack_in;
  logic                           reg_rd_wr_L_in;
  logic [UDP_REG_ADDR_WIDTH-1:0]  reg_addr_in;
  logic [CPCI_NF2_DATA_WIDTH-1:0] reg_data_in;
  logic [UDP_REG_SRC_WIDTH-1:0]   reg_src_in;

  modport master (
    input  cpu_req, cpu_rd_wr_L, cpu_addr, cpu_wr_data,
    output cpu_busy, cpu_ack, cpu_rd_data, cpu_err, cpu_timeout,
    output reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out,
    input  reg_req_in, reg_ack_in, reg_rd_wr_L_in, reg_addr_in, reg_data_in, reg_src_in
  );

  modport slave (
    output cpu_req, cpu_rd_wr_L, cpu_addr, cpu_wr_data,
    input  cpu_busy, cpu_ack, cpu_rd_data, cpu_err, cpu_timeout,
    input  reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out,
    output reg_req_in, reg_ack_in, reg_rd_wr_L_in, reg_addr_in, reg_data_in, reg_src_in
  );
endinterface

// File: rtl/udp_reg_ring_master.sv
// Register ring initiator: launches one CPU access as a single token at the ring head
// and terminates the ring by absorbing the returning token, reporting status to the CPU.
module udp_reg_ring_master #(
  parameter int                           UDP_REG_ADDR_WIDTH  = 23,
  parameter int                           CPCI_NF2_DATA_WIDTH = 32,
  parameter int                           UDP_REG_SRC_WIDTH   = 2,
  parameter logic [UDP_REG_SRC_WIDTH-1:0] SRC_ID              = 2'b01,
  parameter int                           TIMEOUT             = 1024
) (
  input  logic                         clk,
  input  logic                         reset,
  udp_reg_ring_master_if.master        bus,
  output logic [7:0]                   stray_count
);
  // state   | meaning
  // S_IDLE  | nothing outstanding; cpu_req launches a token
  // S_WAIT  | token in flight; waiting for our own return or the timer
  // S_DRAIN | after a timeout; swallow late tokens for TIMEOUT cycles
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_t;

  localparam int TIMER_W = $clog2(TIMEOUT + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
  localparam logic [CPCI_NF2_DATA_WIDTH-1:0] ERR_DATA = CPCI_NF2_DATA_WIDTH'(32'hDEAD_BEEF);

  state_t                         state_q, state_d;
  logic [TIMER_W-1:0]             timer_q, timer_d;
  logic                           pend_rd_q, pend_rd_d;
  logic                           req_q, req_d;
  logic                           rw_q, rw_d;
  logic [UDP_REG_ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [CPCI_NF2_DATA_WIDTH-1:0] data_q, data_d;
  logic [UDP_REG_SRC_WIDTH-1:0]   src_q, src_d;
  logic                           busy_q, busy_d;
  logic                           cpu_ack_q, cpu_ack_d;
  logic                           err_q, err_d;
  logic                           to_q, to_d;
  logic [CPCI_NF2_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [7:0]                     stray_q, stray_d;
  logic                           ret_absorbed;
  logic                           unused_ring_in;

  // Address and direction of a returning token are not checked.
  assign unused_ring_in = ^{bus.reg_addr_in, bus.reg_rd_wr_L_in};

  // A token seen while our own request is still on the head (launch cycle) cannot be ours.
  assign ret_absorbed = (state_q == S_WAIT) && bus.reg_req_in &&
                        (bus.reg_src_in == SRC_ID) && !req_q;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    pend_rd_d = pend_rd_q;
    req_d     = 1'b0;
    rw_d      = 1'b0;
    addr_d    = '0;
    data_d    = '0;
    src_d     = '0;
    cpu_ack_d = 1'b0;
    err_d     = 1'b0;
    to_d      = 1'b0;
    rd_data_d = rd_data_q;
    stray_d   = stray_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.cpu_req) begin
          req_d     = 1'b1;
          rw_d      = bus.cpu_rd_wr_L;
          addr_d    = bus.cpu_addr;
          data_d    = bus.cpu_rd_wr_L ? '0 : bus.cpu_wr_data;
          src_d     = SRC_ID;
          pend_rd_d = bus.cpu_rd_wr_L;
          timer_d   = '0;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ret_absorbed) begin
          cpu_ack_d = 1'b1;
          err_d     = !bus.reg_ack_in;
          if (pend_rd_q) rd_data_d = bus.reg_ack_in ? bus.reg_data_in : ERR_DATA;
          state_d   = S_IDLE;
        end else if (timer_q == TIMER_LAST) begin
          cpu_ack_d = 1'b1;
          err_d     = 1'b1;
          to_d      = 1'b1;
          rd_data_d = ERR_DATA;
          timer_d   = '0;
          state_d   = S_DRAIN;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      S_DRAIN: begin
        if (timer_q == TIMER_LAST) state_d = S_IDLE;
        else                       timer_d = timer_q + TIMER_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);

    if (bus.reg_req_in && !ret_absorbed && (stray_q != 8'hFF)) stray_d = stray_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      pend_rd_q <= 1'b0;
      req_q     <= 1'b0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      src_q     <= '0;
      busy_q    <= 1'b0;
      cpu_ack_q <= 1'b0;
      err_q     <= 1'b0;
      to_q      <= 1'b0;
      rd_data_q <= '0;
      stray_q   <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pend_rd_q <= pend_rd_d;
      req_q     <= req_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      src_q     <= src_d;
      busy_q    <= busy_d;
      cpu_ack_q <= cpu_ack_d;
      err_q     <= err_d;
      to_q      <= to_d;
      rd_data_q <= rd_data_d;
      stray_q   <= stray_d;
    end
  end

  assign bus.reg_req_out     = req_q;
  assign bus.reg_ack_out     = 1'b0;
  assign bus.reg_rd_wr_L_out = rw_q;
  assign bus.reg_addr_out    = addr_q;
  assign bus.reg_data_out    = data_q;
  assign bus.reg_src_out     = src_q;
  assign bus.cpu_busy        = busy_q;
  assign bus.cpu_ack         = cpu_ack_q;
  assign bus.cpu_err         = err_q;
  assign bus.cpu_timeout     = to_q;
  assign bus.cpu_rd_data     = rd_data_q;
  assign stray_count         = stray_q;
endmodule

// File: tb/tb_udp_reg_ring_master.sv
// Self-checking bench for udp_reg_ring_master: directed scenarios plus randomized accesses
// checked against a transaction-level model of the ring initiator.
`timescale 1ns/1ps
module tb_udp_reg_ring_master;
  localparam int AW = 23;
  localparam int DW = 32;
  localparam int SW = 2;
  localparam int TO = 16;
  localparam logic [SW-1:0] SRC  = 2'b01;
  localparam logic [31:0]   DEAD = 32'hDEAD_BEEF;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] stray_count;
  int         checks = 0;
  int         errors = 0;
  logic [31:0] model_rd_data;
  int         model_stray;

  typedef struct {
    logic l_req, l_ack, l_rw, l_busy;
    logic [AW-1:0] l_addr;
    logic [DW-1:0] l_data;
    logic [SW-1:0] l_src;
    int pulses, early_acks;
    logic c_ack, c_err, c_to, c_busy;
    logic [DW-1:0] c_data;
  } obs_t;

  udp_reg_ring_master_if #(.UDP_REG_ADDR_WIDTH(AW), .CPCI_NF2_DATA_WIDTH(DW),
                           .UDP_REG_SRC_WIDTH(SW)) bus ();

  udp_reg_ring_master #(.UDP_REG_ADDR_WIDTH(AW), .CPCI_NF2_DATA_WIDTH(DW),
                        .UDP_REG_SRC_WIDTH(SW), .SRC_ID(SRC), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .bus(bus), .stray_count(stray_count));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ring_idle();
    bus.reg_req_in = 1'b0; bus.reg_ack_in = 1'b0; bus.reg_rd_wr_L_in = 1'b0;
    bus.reg_addr_in = '0; bus.reg_data_in = '0; bus.reg_src_in = '0;
  endtask

  task automatic ring_return(input logic [SW-1:0] src, input logic ack, input logic [DW-1:0] d);
    bus.reg_req_in = 1'b1; bus.reg_src_in = src; bus.reg_ack_in = ack;
    bus.reg_data_in = d; bus.reg_addr_in = AW'($urandom); bus.reg_rd_wr_L_in = 1'(($urandom));
  endtask

  function automatic void bump_stray(input int n);
    model_stray = (model_stray + n > 255) ? 255 : model_stray + n;
  endfunction

  // Launch one access, return it after d cycles (launch cycle N+1, return at M=N+1+d).
  task automatic do_access(input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                           input int d, input logic ack, input logic [DW-1:0] rdat, output obs_t o);
    bus.cpu_req = 1'b1; bus.cpu_rd_wr_L = rd; bus.cpu_addr = a; bus.cpu_wr_data = wd;
    step();
    bus.cpu_req = 1'b0;
    o.l_req = bus.reg_req_out; o.l_ack = bus.reg_ack_out; o.l_rw = bus.reg_rd_wr_L_out;
    o.l_addr = bus.reg_addr_out; o.l_data = bus.reg_data_out; o.l_src = bus.reg_src_out;
    o.l_busy = bus.cpu_busy;
    o.pulses = int'(bus.reg_req_out);
    o.early_acks = int'(bus.cpu_ack);
    for (int i = 0; i < d; i++) begin
      step();
      o.pulses += int'(bus.reg_req_out);
      o.early_acks += int'(bus.cpu_ack);
    end
    ring_return(SRC, ack, rdat);
    step();
    ring_idle();
    o.c_ack = bus.cpu_ack; o.c_err = bus.cpu_err; o.c_to = bus.cpu_timeout;
    o.c_busy = bus.cpu_busy; o.c_data = bus.cpu_rd_data;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    checks++;
    if ({bus.reg_req_out, bus.reg_ack_out, bus.reg_rd_wr_L_out, bus.reg_addr_out,
         bus.reg_data_out, bus.reg_src_out} !== '0) begin
      errors++; $display("FAIL reset_ring_out: got req=%b addr=%h data=%h src=%h, expected all 0",
                         bus.reg_req_out, bus.reg_addr_out, bus.reg_data_out, bus.reg_src_out);
    end
    checks++;
    if ({bus.cpu_ack, bus.cpu_err, bus.cpu_timeout, bus.cpu_busy} !== 4'b0000) begin
      errors++; $display("FAIL reset_cpu_flags: got ack/err/to/busy=%b, expected 0000",
                         {bus.cpu_ack, bus.cpu_err, bus.cpu_timeout, bus.cpu_busy});
    end
    checks++;
    if (bus.cpu_rd_data !== 32'h0 || stray_count !== 8'h0) begin
      errors++; $display("FAIL reset_data: got rd_data=%h stray=%0d, expected 0 and 0",
                         bus.cpu_rd_data, stray_count);
    end
    reset = 1'b0;
    step();
    checks++;
    if (bus.cpu_busy !== 1'b0 || bus.reg_req_out !== 1'b0) begin
      errors++; $display("FAIL reset_release_idle: got busy=%b req=%b, expected 0 0",
                         bus.cpu_busy, bus.reg_req_out);
    end
    model_rd_data = 32'h0;
    model_stray = 0;
  endtask

  task automatic test_write_ack();
    obs_t o;
    do_access(1'b0, 23'h400010, 32'h12345678, 5, 1'b1, 32'h12345678, o);
    checks++;
    if (o.l_req !== 1'b1 || o.pulses !== 1) begin
      errors++; $display("FAIL wr_launch_pulse: got req=%b pulses=%0d, expected 1 and 1", o.l_req, o.pulses);
    end
    checks++;
    if ({o.l_ack, o.l_rw, o.l_addr, o.l_data, o.l_src} !== {1'b0, 1'b0, 23'h400010, 32'h12345678, SRC}) begin
      errors++; $display("FAIL wr_launch_fields: got ack=%b rw=%b addr=%h data=%h src=%h, expected 0 0 400010 12345678 %h",
                         o.l_ack, o.l_rw, o.l_addr, o.l_data, o.l_src, SRC);
    end
    checks++;
    if (o.early_acks !== 0 || o.c_ack !== 1'b1 || o.c_busy !== 1'b0) begin
      errors++; $display("FAIL wr_ack_timing: got early=%0d ack=%b busy=%b, expected 0 1 0",
                         o.early_acks, o.c_ack, o.c_busy);
    end
    checks++;
    if (o.c_err !== 1'b0 || o.c_to !== 1'b0 || o.c_data !== model_rd_data) begin
      errors++; $display("FAIL wr_status: got err=%b to=%b rd_data=%h, expected 0 0 %h",
                         o.c_err, o.c_to, o.c_data, model_rd_data);
    end
    step();
    checks++;
    if (bus.cpu_ack !== 1'b0 || bus.cpu_busy !== 1'b0) begin
      errors++; $display("FAIL wr_ack_single: got ack=%b busy=%b, expected 0 0", bus.cpu_ack, bus.cpu_busy);
    end
  endtask

  task automatic test_read_data();
    obs_t o;
    do_access(1'b1, 23'h400004, 32'h5555AAAA, 3, 1'b1, 32'hCAFEF00D, o);
    model_rd_data = 32'hCAFEF00D;
    checks++;
    if (o.l_req !== 1'b1 || o.l_rw !== 1'b1 || o.l_data !== 32'h0 || o.l_addr !== 23'h400004 || o.l_busy !== 1'b1) begin
      errors++; $display("FAIL rd_launch: got req=%b rw=%b data=%h addr=%h busy=%b, expected 1 1 0 400004 1",
                         o.l_req, o.l_rw, o.l_data, o.l_addr, o.l_busy);
    end
    checks++;
    if (o.c_ack !== 1'b1 || o.c_busy !== 1'b0 || o.c_err !== 1'b0 || o.c_data !== model_rd_data) begin
      errors++; $display("FAIL rd_complete: got ack=%b busy=%b err=%b data=%h, expected 1 0 0 %h",
                         o.c_ack, o.c_busy, o.c_err, o.c_data, model_rd_data);
    end
    step();
    checks++;
    if (bus.cpu_rd_data !== model_rd_data || bus.cpu_err !== 1'b0) begin
      errors++; $display("FAIL rd_data_hold: got %h err=%b, expected %h 0", bus.cpu_rd_data, bus.cpu_err, model_rd_data);
    end
  endtask

  task automatic test_no_responder();
    obs_t o;
    do_access(1'b1, 23'h000100, 32'h0, 2, 1'b1, 32'h11112222, o);
    model_rd_data = 32'h11112222;
    do_access(1'b0, 23'h000104, 32'h33334444, 4, 1'b0, 32'h33334444, o);
    checks++;
    if (o.c_ack !== 1'b1 || o.c_err !== 1'b1 || o.c_to !== 1'b0 || o.c_data !== model_rd_data) begin
      errors++; $display("FAIL nr_write: got ack=%b err=%b to=%b data=%h, expected 1 1 0 %h",
                         o.c_ack, o.c_err, o.c_to, o.c_data, model_rd_data);
    end
    do_access(1'b1, 23'h000108, 32'h0, 6, 1'b0, 32'h0, o);
    model_rd_data = DEAD;
    checks++;
    if (o.c_ack !== 1'b1 || o.c_err !== 1'b1 || o.c_to !== 1'b0 || o.c_data !== DEAD) begin
      errors++; $display("FAIL nr_read: got ack=%b err=%b to=%b data=%h, expected 1 1 0 deadbeef",
                         o.c_ack, o.c_err, o.c_to, o.c_data);
    end
    step();
    checks++;
    if (bus.cpu_err !== 1'b0 || bus.cpu_ack !== 1'b0) begin
      errors++; $display("FAIL nr_err_clear: got err=%b ack=%b, expected 0 0", bus.cpu_err, bus.cpu_ack);
    end
  endtask

  task automatic test_random();
    obs_t o;
    logic rd, ack;
    logic [AW-1:0] a;
    logic [DW-1:0] wd, rdat, exp_data;
    int d;
    for (int i = 0; i < 24; i++) begin
      rd = 1'($urandom_range(0, 1)); ack = ($urandom_range(0, 3) != 0);
      a = AW'($urandom); wd = $urandom; rdat = $urandom; d = $urandom_range(1, 14);
      do_access(rd, a, wd, d, ack, rdat, o);
      exp_data = rd ? (ack ? rdat : DEAD) : model_rd_data;
      model_rd_data = exp_data;
      checks++;
      if (o.pulses !== 1 || {o.l_rw, o.l_addr, o.l_data, o.l_src} !== {rd, a, (rd ? 32'h0 : wd), SRC}) begin
        errors++; $display("FAIL rnd_launch[%0d]: got pulses=%0d rw=%b addr=%h data=%h src=%h, expected 1 %b %h %h %h",
                           i, o.pulses, o.l_rw, o.l_addr, o.l_data, o.l_src, rd, a, (rd ? 32'h0 : wd), SRC);
      end
      checks++;
      if (o.early_acks !== 0 || {o.c_ack, o.c_err, o.c_to, o.c_busy} !== {1'b1, !ack, 1'b0, 1'b0}) begin
        errors++; $display("FAIL rnd_status[%0d]: got early=%0d ack/err/to/busy=%b, expected 0 %b",
                           i, o.early_acks, {o.c_ack, o.c_err, o.c_to, o.c_busy}, {1'b1, !ack, 1'b0, 1'b0});
      end
      checks++;
      if (o.c_data !== exp_data) begin
        errors++; $display("FAIL rnd_data[%0d]: got %h, expected %h", i, o.c_data, exp_data);
      end
    end
  endtask

  task automatic test_back_to_back();
    int pulses, acks;
    logic [DW-1:0] d1, d2;
    d1 = $urandom; d2 = $urandom;
    bus.cpu_req = 1'b1; bus.cpu_rd_wr_L = 1'b1; bus.cpu_addr = AW'($urandom);
    step();
    pulses = int'(bus.reg_req_out); acks = 0;
    for (int i = 0; i < 3; i++) begin
      step(); pulses += int'(bus.reg_req_out); acks += int'(bus.cpu_ack);
    end
    ring_return(SRC, 1'b1, d1);
    step();
    ring_idle();
    checks++;
    if (pulses !== 1 || acks !== 0) begin
      errors++; $display("FAIL b2b_held_ignored: got pulses=%0d acks=%0d, expected 1 0", pulses, acks);
    end
    checks++;
    if (bus.cpu_ack !== 1'b1 || bus.cpu_busy !== 1'b0 || bus.cpu_rd_data !== d1) begin
      errors++; $display("FAIL b2b_first: got ack=%b busy=%b data=%h, expected 1 0 %h",
                         bus.cpu_ack, bus.cpu_busy, bus.cpu_rd_data, d1);
    end
    model_rd_data = d1;
    step();
    checks++;
    if (bus.reg_req_out !== 1'b1 || bus.cpu_busy !== 1'b1 || bus.cpu_ack !== 1'b0) begin
      errors++; $display("FAIL b2b_relaunch: got req=%b busy=%b ack=%b, expected 1 1 0",
                         bus.reg_req_out, bus.cpu_busy, bus.cpu_ack);
    end
    bus.cpu_req = 1'b0;
    step(); step();
    ring_return(SRC, 1'b1, d2);
    step();
    ring_idle();
    model_rd_data = d2;
    checks++;
    if (bus.cpu_ack !== 1'b1 || bus.cpu_rd_data !== d2) begin
      errors++; $display("FAIL b2b_second: got ack=%b data=%h, expected 1 %h", bus.cpu_ack, bus.cpu_rd_data, d2);
    end
  endtask

  task automatic test_timeout_boundary();
    obs_t o;
    logic [DW-1:0] rdat;
    rdat = $urandom;
    do_access(1'b1, 23'h000200, 32'h0, TO - 1, 1'b1, rdat, o);
    model_rd_data = rdat;
    checks++;
    if (o.early_acks !== 0 || {o.c_ack, o.c_err, o.c_to} !== 3'b100 || o.c_data !== rdat || o.c_busy !== 1'b0) begin
      errors++; $display("FAIL expiry_return: got early=%0d ack/err/to=%b busy=%b data=%h, expected 0 100 0 %h",
                         o.early_acks, {o.c_ack, o.c_err, o.c_to}, o.c_busy, o.c_data, rdat);
    end
  endtask

  task automatic test_timeout_drain();
    int n;
    logic [DW-1:0] rdat;
    bus.cpu_req = 1'b1; bus.cpu_rd_wr_L = 1'b1; bus.cpu_addr = 23'h000300;
    step();
    bus.cpu_req = 1'b0;
    n = 0;
    while (bus.cpu_ack !== 1'b1 && n < 40) begin step(); n++; end
    checks++;
    if (n !== TO) begin
      errors++; $display("FAIL timeout_latency: got ack %0d cycles after launch, expected %0d", n, TO);
    end
    model_rd_data = DEAD;
    checks++;
    if ({bus.cpu_err, bus.cpu_timeout, bus.cpu_busy} !== 3'b111 || bus.cpu_rd_data !== DEAD) begin
      errors++; $display("FAIL timeout_status: got err/to/busy=%b data=%h, expected 111 deadbeef",
                         {bus.cpu_err, bus.cpu_timeout, bus.cpu_busy}, bus.cpu_rd_data);
    end
    bus.cpu_req = 1'b1;
    step();
    checks++;
    if ({bus.cpu_ack, bus.cpu_err, bus.cpu_timeout, bus.cpu_busy} !== 4'b0001) begin
      errors++; $display("FAIL drain_flags: got ack/err/to/busy=%b, expected 0001",
                         {bus.cpu_ack, bus.cpu_err, bus.cpu_timeout, bus.cpu_busy});
    end
    ring_return(SRC, 1'b1, 32'hFEEDFACE);
    step();
    ring_idle();
    bump_stray(1);
    checks++;
    if (stray_count !== 8'(model_stray) || bus.cpu_ack !== 1'b0) begin
      errors++; $display("FAIL drain_stray: got stray=%0d ack=%b, expected %0d 0", stray_count, bus.cpu_ack, model_stray);
    end
    n = 2;
    while (bus.reg_req_out !== 1'b1 && n < 40) begin step(); n++; end
    checks++;
    if (n !== TO + 1) begin
      errors++; $display("FAIL drain_relaunch: got launch %0d cycles after timeout ack, expected %0d", n, TO + 1);
    end
    bus.cpu_req = 1'b0;
    rdat = $urandom;
    step();
    ring_return(SRC, 1'b1, rdat);
    step();
    ring_idle();
    model_rd_data = rdat;
    checks++;
    if (bus.cpu_ack !== 1'b1 || bus.cpu_timeout !== 1'b0 || bus.cpu_rd_data !== rdat) begin
      errors++; $display("FAIL drain_next_access: got ack=%b to=%b data=%h, expected 1 0 %h",
                         bus.cpu_ack, bus.cpu_timeout, bus.cpu_rd_data, rdat);
    end
  endtask

  task automatic test_foreign_stray();
    int acks;
    bus.cpu_req = 1'b1; bus.cpu_rd_wr_L = 1'b0; bus.cpu_addr = 23'h000400; bus.cpu_wr_data = $urandom;
    step();
    bus.cpu_req = 1'b0;
    ring_return(SRC, 1'b1, 32'h0);
    step();
    acks = int'(bus.cpu_ack);
    ring_return(2'b10, 1'b1, 32'h0);
    step();
    acks += int'(bus.cpu_ack);
    ring_idle();
    bump_stray(2);
    checks++;
    if (stray_count !== 8'(model_stray)) begin
      errors++; $display("FAIL foreign_stray_count: got %0d, expected %0d", stray_count, model_stray);
    end
    step();
    acks += int'(bus.cpu_ack);
    checks++;
    if (acks !== 0 || bus.cpu_busy !== 1'b1) begin
      errors++; $display("FAIL foreign_not_completed: got acks=%0d busy=%b, expected 0 1", acks, bus.cpu_busy);
    end
    ring_return(SRC, 1'b1, 32'h0);
    step();
    ring_idle();
    checks++;
    if (bus.cpu_ack !== 1'b1 || bus.cpu_err !== 1'b0 || stray_count !== 8'(model_stray)) begin
      errors++; $display("FAIL foreign_then_match: got ack=%b err=%b stray=%0d, expected 1 0 %0d",
                         bus.cpu_ack, bus.cpu_err, stray_count, model_stray);
    end
  endtask

  task automatic test_stray_saturation();
    int acks, reqs;
    acks = 0; reqs = 0;
    step();
    for (int i = 0; i < 300; i++) begin
      ring_return(SW'($urandom), 1'($urandom), $urandom);
      step();
      acks += int'(bus.cpu_ack); reqs += int'(bus.reg_req_out);
    end
    ring_idle();
    bump_stray(300);
    checks++;
    if (stray_count !== 8'(model_stray) || acks !== 0 || reqs !== 0) begin
      errors++; $display("FAIL stray_saturate: got stray=%0d acks=%0d reqs=%0d, expected %0d 0 0",
                         stray_count, acks, reqs, model_stray);
    end
  endtask

  task automatic test_reset_mid_wait();
    obs_t o;
    logic [DW-1:0] rdat;
    bus.cpu_req = 1'b1; bus.cpu_rd_wr_L = 1'b0; bus.cpu_addr = 23'h000500; bus.cpu_wr_data = $urandom;
    step();
    bus.cpu_req = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_stray = 0; model_rd_data = 32'h0;
    checks++;
    if ({bus.reg_req_out, bus.reg_rd_wr_L_out, bus.reg_addr_out, bus.reg_data_out, bus.reg_src_out,
         bus.cpu_ack, bus.cpu_err, bus.cpu_timeout, bus.cpu_busy, bus.cpu_rd_data, stray_count} !== '0) begin
      errors++; $display("FAIL midreset_outputs: got busy=%b ack=%b stray=%0d rd=%h, expected all 0",
                         bus.cpu_busy, bus.cpu_ack, stray_count, bus.cpu_rd_data);
    end
    ring_return(SRC, 1'b1, 32'h0);
    step();
    ring_idle();
    bump_stray(1);
    step();
    checks++;
    if (bus.cpu_ack !== 1'b0 || stray_count !== 8'(model_stray)) begin
      errors++; $display("FAIL midreset_late_token: got ack=%b stray=%0d, expected 0 %0d",
                         bus.cpu_ack, stray_count, model_stray);
    end
    rdat = $urandom;
    do_access(1'b1, 23'h000504, 32'h0, 2, 1'b1, rdat, o);
    model_rd_data = rdat;
    checks++;
    if (o.c_ack !== 1'b1 || o.c_err !== 1'b0 || o.c_data !== rdat) begin
      errors++; $display("FAIL midreset_new_access: got ack=%b err=%b data=%h, expected 1 0 %h",
                         o.c_ack, o.c_err, o.c_data, rdat);
    end
  endtask

  initial begin
    bus.cpu_req = 1'b0; bus.cpu_rd_wr_L = 1'b0; bus.cpu_addr = '0; bus.cpu_wr_data = '0;
    ring_idle();
    test_reset();
    test_write_ack();
    test_read_data();
    test_no_responder();
    test_random();
    test_back_to_back();
    test_timeout_boundary();
    test_timeout_drain();
    test_foreign_stray();
    test_stray_saturation();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/udp_reg_ring_master.md
# udp_reg_ring_master

Initiator for the UDP register ring. Takes one CPU-side register access at a time, launches it as a single request token into the head of the daisy-chained register bus (`reg_*_out`), and terminates the ring by absorbing the token when it returns (`reg_*_in`). It then reports completion, read data and error status back to the CPU side. It sits between the CPCI register bridge and the first ring member, for example the output port lookup stage.

## Interface
Parameters:
- `UDP_REG_SRC_WIDTH`, default 2: width of the source tag.
- `SRC_ID`, default 2'b01: tag stamped on launched requests; returns are matched on it.
- `TIMEOUT`, default 1024: maximum cycles in WAIT before a timeout is declared (≥2).

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high reset.
- `cpu_req` in 1: access request; sampled only in IDLE.
- `cpu_rd_wr_L` in 1: 1 = read, 0 = write.
- `cpu_addr` in `UDP_REG_ADDR_WIDTH`: register address.
- `cpu_wr_data` in `CPCI_NF2_DATA_WIDTH`: write data.
- `cpu_busy` out 1: high in every state except IDLE.
- `cpu_ack` out 1: one-cycle completion pulse.
- `cpu_rd_data` out `CPCI_NF2_DATA_WIDTH`: read result; held until the next `cpu_ack`.
- `cpu_err` out 1: valid with `cpu_ack`; no responder or timeout.
- `cpu_timeout` out 1: valid with `cpu_ack`; timeout occurred.
- `stray_count` out 8: saturating count of discarded ring tokens.
- `reg_req_out`, `reg_ack_out`, `reg_rd_wr_L_out` out 1 each: ring head, control.
- `reg_addr_out` out `UDP_REG_ADDR_WIDTH`: ring head, address.
- `reg_data_out` out `CPCI_NF2_DATA_WIDTH`: ring head, data.
- `reg_src_out` out `UDP_REG_SRC_WIDTH`: ring head, source tag.
- `reg_req_in`, `reg_ack_in`, `reg_rd_wr_L_in` in 1 each: ring tail, control.
- `reg_addr_in` in `UDP_REG_ADDR_WIDTH`: ring tail, address.
- `reg_data_in` in `CPCI_NF2_DATA_WIDTH`: ring tail, data.
- `reg_src_in` in `UDP_REG_SRC_WIDTH`: ring tail, source tag.

## Operation
FSM states: IDLE, WAIT, DRAIN. All outputs are registered.

- **IDLE:** `cpu_req`=1 causes a launch.
  - Next cycle: `reg_req_out`=1 for exactly one cycle.
  - `reg_ack_out`=0, `reg_src_out`=`SRC_ID`, `reg_rd_wr_L_out`=`cpu_rd_wr_L`, `reg_addr_out`=`cpu_addr`.
  - `reg_data_out`=`cpu_wr_data` for a write, 0 for a read.
  - FSM moves to WAIT and the timer clears to 0.
- **Ring outputs when idle:** while `reg_req_out`=0, every `reg_*_out` field is 0.
- **WAIT, matching return:** a return is `reg_req_in`=1 with `reg_src_in`==`SRC_ID`. The token is absorbed, never forwarded. Next cycle: `cpu_ack`=1 and FSM → IDLE.
  - `reg_ack_in`=1: `cpu_err`=0; `cpu_rd_data`=`reg_data_in` for a read, unchanged for a write.
  - `reg_ack_in`=0 (no responder): `cpu_err`=1; `cpu_rd_data`=32'hDEAD_BEEF for a read.
- **WAIT, timer:** increments every cycle without a matching return; its width is ceil(log2(TIMEOUT+1)) bits.
  - When timer==TIMEOUT-1 with no return that cycle, the next cycle gives `cpu_ack`=1, `cpu_err`=1, `cpu_timeout`=1, `cpu_rd_data`=32'hDEAD_BEEF. FSM → DRAIN.
- **DRAIN:** lasts exactly `TIMEOUT` cycles, then → IDLE. Its purpose is to absorb late tokens before a new launch.
- **Stray tokens:** discarded and counted in `stray_count`, saturating at 255. A stray token is any `reg_req_in`=1 that is:
  - in IDLE or DRAIN, or
  - in WAIT with `reg_src_in`≠`SRC_ID`.
- **Flag lifetime:** `cpu_err` and `cpu_timeout` are cleared on the cycle after the `cpu_ack` pulse.

## Timing
- **Reset values:** all `reg_*_out`, `cpu_ack`, `cpu_err`, `cpu_timeout`, `cpu_busy`, `stray_count` and `cpu_rd_data` are 0. FSM = IDLE.
- **Launch latency:** `cpu_req` sampled in IDLE at cycle N → `reg_req_out` at N+1 → `cpu_busy`=1 from N+1.
- **Completion latency:** matching return at cycle M (M ≥ N+2) → `cpu_ack` at M+1 → `cpu_busy`=0 at M+1 → earliest next launch at M+2.
- **Back-to-back requests:** `cpu_req` held high across `cpu_ack` is accepted again at M+1 and launches at M+2.
- **Simultaneous events:**
  - A matching return on the timer-expiry cycle counts as a normal completion, not a timeout.
  - A return on the launch cycle N+1 is impossible with registered outputs. If `reg_req_in` is seen then, it is stray.
- **Ignored inputs:** `cpu_req` outside IDLE is ignored, not queued. `reg_addr_in` and `reg_rd_wr_L_in` are not checked on a return.
- **Reset mid-operation:** the FSM returns to IDLE and no `cpu_ack` is issued. A token already in flight later arrives in IDLE and is counted as stray.

## Test plan
- **Write with ack:** write, addr 0x400010, data 0x12345678; loopback ring sets ack after 5 cycles → one `reg_req_out` pulse with the exact fields; `cpu_ack` 1 cycle after the return; `cpu_err`=0.
- **Read with data:** read, addr 0x400004; ring returns ack=1, data 0xCAFEF00D → `cpu_rd_data`=0xCAFEF00D; `reg_data_out` was 0 at launch; `cpu_busy` falls with `cpu_ack`.
- **No responder:** ring passes the token unchanged (ack=0) → `cpu_err`=1, `cpu_timeout`=0, `cpu_rd_data`=0xDEADBEEF.
- **Timeout and drain:** `TIMEOUT`=16, ring never returns → `cpu_ack` with `cpu_timeout`=1 exactly 16 cycles after the launch cycle. A token injected during DRAIN gives `stray_count`=1. A `cpu_req` during DRAIN is ignored; a held request launches only after the 16 DRAIN cycles.
- **Foreign and stray tokens:** in WAIT, inject src=2'b10 → not completed, `stray_count`+1. Then inject the matching token → completes. 300 idle strays → `stray_count` saturates at 255.
- **Reset mid-WAIT:** assert `reset` 1 cycle during WAIT → all outputs 0 next cycle; no `cpu_ack`. The late return is counted as stray; a new request completes normally.
